// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address width, reset vector, special encodings and the
// instruction-fetch FSM state type.
package cpu_pkg;

    localparam int              XLEN         = 64;
    localparam logic [XLEN-1:0] RESET_PC     = 64'h0000_0000_8000_0000;
    localparam logic [31:0]     INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic {
        IFU_RUN  = 1'b0,
        IFU_HALT = 1'b1
    } ifu_state_e;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush. The head output reads as zero while the FIFO is empty.
// A push is accepted when full only if a pop happens in the same cycle.
module ifu_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // NOTE: storage is not reset; the count guards every read, so only control state needs reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC, credit-limited in-order imem reads, buffered {instr, pc} to decode.
// Optional IFU_EBREAK_HALT_EN: a fetched ebreak halts further requests until the next redirect.
module ifu_fetch #(
    parameter int                  XLEN       = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0]     RESET_PC   = cpu_pkg::RESET_PC,
    parameter int                  FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc
);

    import cpu_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = 32 + XLEN;

    ifu_state_e      state;
    logic [XLEN-1:0] pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] unused_tag_count;
    logic [CNT_W:0]   in_use;
    logic             credit_ok;
    logic             req_fire;
    logic             rsp_drop;
    logic             rsp_keep;
    logic             pop;
    logic             ebreak_hit;
    logic             tag_flush;
    logic [XLEN-1:0]  tag_pc;
    logic [ENT_W-1:0] head;
    logic [1:0]       unused_redirect_lsb;

    assign unused_redirect_lsb = redirect_pc[1:0];

    // Buffered words plus requests still in flight may never exceed the buffer size.
    assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit_ok = in_use < (CNT_W + 1)'(FIFO_DEPTH);

    assign imem_req_valid = ~rst & (state == IFU_RUN) & ~redirect_valid & credit_ok;
    assign imem_req_addr  = pc;

    assign req_fire = imem_req_valid & imem_req_ready;
    assign rsp_drop = imem_rsp_valid & ((drop_cnt != '0) | redirect_valid);
    assign rsp_keep = imem_rsp_valid & ~rsp_drop;
    assign pop      = instr_valid & instr_ready;

    assign outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

`ifdef IFU_EBREAK_HALT_EN
    assign ebreak_hit = rsp_keep & (imem_rsp_data == INSTR_EBREAK);
`else
    assign ebreak_hit = 1'b0;
`endif

    // Tags of requests that will be dropped are discarded; drop_cnt accounts for them instead.
    assign tag_flush = redirect_valid | ebreak_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IFU_RUN;
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                state    <= IFU_RUN;
                pc       <= {redirect_pc[XLEN-1:2], 2'b00};
                drop_cnt <= outstanding_next;
            end else begin
                if (req_fire) pc <= pc + XLEN'(4);
                if (ebreak_hit) begin
                    state    <= IFU_HALT;
                    drop_cnt <= outstanding_next;
                end else if (rsp_drop) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
        end
    end

    ifu_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .flush (tag_flush),
        .push  (req_fire),
        .din   (pc),
        .pop   (rsp_keep),
        .dout  (tag_pc),
        .count (unused_tag_count)
    );

    ifu_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_instr_q (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (rsp_keep),
        .din   ({imem_rsp_data, tag_pc}),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count)
    );

    assign instr_valid = (fifo_count != '0);
    assign instr       = head[ENT_W-1:XLEN];
    assign instr_pc    = head[XLEN-1:0];

endmodule
